// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit (sequencer, datapath, bench).
package multdiv_pkg;

    localparam int unsigned MULT_STEPS_DEF = 16;
    localparam int unsigned DIV_STEPS_DEF  = 32;
    localparam int unsigned CNT_W_DEF      = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_step_counter.sv
// Iteration index counter for the multdiv sequencer: sync clear has priority over enable.
module multdiv_step_counter
    import multdiv_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide unit: load, fixed step count, completion pulse.
// Optional early multiply termination on mplier_zero when MULTDIV_SEQ_EARLY_TERM_EN is defined.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned MULT_STEPS = MULT_STEPS_DEF,
    parameter int unsigned DIV_STEPS  = DIV_STEPS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             mplier_zero,
    output logic             load,
    output logic             step_en,
    output logic             op_is_div,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    state_t state, state_d;
    logic   op_is_div_d;
    logic   exc_d;
    logic   req;
    logic   last_step;
    logic   early_done;
    logic   cnt_clr;
    logic   cnt_en;

    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk   (clk),
        .rst_n (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (step_cnt)
    );

`ifdef MULTDIV_SEQ_EARLY_TERM_EN
    assign early_done = (op_is_div == OP_MULT) & mplier_zero;
`else
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
    assign early_done         = 1'b0;
`endif

    assign req       = ctrl_mult | ctrl_div;
    assign last_step = (op_is_div == OP_DIV) ? (step_cnt == CNT_W'(DIV_STEPS - 1))
                                             : (step_cnt == CNT_W'(MULT_STEPS - 1));

    // Any request restarts in LOAD, aborting whatever is in flight; multiply wins a tie.
    always_comb begin
        state_d     = state;
        op_is_div_d = op_is_div;
        exc_d       = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        if (req) begin
            state_d     = S_LOAD;
            op_is_div_d = ctrl_mult ? OP_MULT : OP_DIV;
            cnt_clr     = 1'b1;
        end else begin
            case (state)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    if (divisor_zero && (op_is_div == OP_DIV)) begin
                        state_d = S_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_step || early_done) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they align with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            op_is_div  <= OP_MULT;
            load       <= 1'b0;
            step_en    <= 1'b0;
            busy       <= 1'b0;
            result_rdy <= 1'b0;
            exception  <= 1'b0;
        end else begin
            state      <= state_d;
            op_is_div  <= op_is_div_d;
            load       <= (state_d == S_LOAD);
            step_en    <= (state_d == S_RUN);
            busy       <= (state_d == S_LOAD) || (state_d == S_RUN);
            result_rdy <= (state_d == S_DONE);
            exception  <= exc_d;
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a completion scoreboard (due edge, op type, exception, step count).
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    localparam int unsigned W      = 6;
    localparam int unsigned N_MULT = 16;
    localparam int unsigned N_DIV  = 32;

    typedef struct {
        int unsigned due;
        logic        div;
        logic        exc;
        int unsigned steps;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ctrl_mult;
    logic         ctrl_div;
    logic         divisor_zero;
    logic         mplier_zero;
    logic         load;
    logic         step_en;
    logic         op_is_div;
    logic [W-1:0] step_cnt;
    logic         busy;
    logic         result_rdy;
    logic         exception;
    logic [11:0]  outs;

    exp_t        sb[$];
    int unsigned edge_cnt   = 0;
    int unsigned steps_seen = 0;
    int unsigned n_checks   = 0;
    int unsigned n_fail     = 0;

    multdiv_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .divisor_zero (divisor_zero),
        .mplier_zero  (mplier_zero),
        .load         (load),
        .step_en      (step_en),
        .op_is_div    (op_is_div),
        .step_cnt     (step_cnt),
        .busy         (busy),
        .result_rdy   (result_rdy),
        .exception    (exception)
    );

    assign outs = {load, step_en, op_is_div, busy, result_rdy, exception, step_cnt};

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is sampled at the next posedge, returns at the LOAD-cycle negedge.
    task automatic issue(input logic m, input logic d, input logic ediv, input logic eexc,
                         input int unsigned steps, input int unsigned lat);
        exp_t e;
        e.due   = edge_cnt + 1 + lat;
        e.div   = ediv;
        e.exc   = eexc;
        e.steps = steps;
        sb.push_back(e);
        ctrl_mult = m;
        ctrl_div  = d;
        @(negedge clk);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic wait_cnt(input int unsigned val);
        int unsigned b = 0;
        while (!(step_en === 1'b1 && step_cnt == W'(val)) && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("reach_cnt", 32'(b < 100), 1);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned b = 0;
        while (sb.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("drain", 32'(sb.size()), 0);
    endtask

    // Scoreboard side: count step_en since the last load, compare each completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            steps_seen = 0;
        end else begin
            if (load) steps_seen = 0;
            if (step_en) steps_seen++;
            if (result_rdy) begin
                check("rdy_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rdy_edge", edge_cnt, e.due);
                    check("rdy_op", 32'(op_is_div), 32'(e.div));
                    check("rdy_exc", 32'(exception), 32'(e.exc));
                    check("rdy_steps", steps_seen, e.steps);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        divisor_zero = 1'b0;
        mplier_zero  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'({busy, load}), 0);

        // multiply, cycle by cycle
        issue(1'b1, 1'b0, OP_MULT, 1'b0, N_MULT, N_MULT + 1);
        check("mul_load", 32'({load, busy, step_en}), 6);
        check("mul_op", 32'(op_is_div), 0);
        for (int i = 0; i < int'(N_MULT); i++) begin
            @(negedge clk);
            check("mul_step", 32'({load, step_en, busy}), 3);
            check("mul_cnt", 32'(step_cnt), i);
        end
        @(negedge clk);
        check("mul_done", 32'({result_rdy, busy, step_en, exception}), 8);
        check("mul_cnt_hold", 32'(step_cnt), N_MULT - 1);
        @(negedge clk);
        check("mul_idle", 32'({result_rdy, busy}), 0);

        // async reset mid-run
        issue(1'b1, 1'b0, OP_MULT, 1'b0, N_MULT, N_MULT + 1);
        wait_cnt(7);
        #2 rst = 1'b0;
        #1 check("async_rst", 32'(outs), 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 32'({busy, load, result_rdy}), 0);
        end

        // divide by zero
        divisor_zero = 1'b1;
        issue(1'b0, 1'b1, OP_DIV, 1'b1, 0, 1);
        check("dz_load", 32'({load, op_is_div}), 3);
        @(negedge clk);
        check("dz_done", 32'({result_rdy, exception, step_en, busy}), 12);
        divisor_zero = 1'b0;
        @(negedge clk);
        check("dz_exc_clear", 32'({exception, result_rdy}), 0);

        // normal divide
        issue(1'b0, 1'b1, OP_DIV, 1'b0, N_DIV, N_DIV + 1);
        check("div_op", 32'(op_is_div), 1);
        drain(60);

        // divide restarted at cnt 10
        @(negedge clk);
        issue(1'b0, 1'b1, OP_DIV, 1'b0, N_DIV, N_DIV + 1);
        wait_cnt(10);
        void'(sb.pop_back());
        issue(1'b0, 1'b1, OP_DIV, 1'b0, N_DIV, N_DIV + 1);
        check("restart_load", 32'({load, step_en, step_cnt}), 32'h80);
        drain(60);

        // simultaneous requests: multiply wins
        @(negedge clk);
        issue(1'b1, 1'b1, OP_MULT, 1'b0, N_MULT, N_MULT + 1);
        check("both_op", 32'(op_is_div), 0);
        drain(40);

        // new request during DONE goes straight to LOAD
        @(negedge clk);
        issue(1'b1, 1'b0, OP_MULT, 1'b0, N_MULT, N_MULT + 1);
        wait_cnt(N_MULT - 1);
        @(negedge clk);
        check("done_rdy", 32'(result_rdy), 1);
        issue(1'b0, 1'b1, OP_DIV, 1'b0, N_DIV, N_DIV + 1);
        check("done_to_load", 32'({load, busy, op_is_div}), 7);
        drain(60);

        // mplier_zero raised at cnt 3 of a multiply
        @(negedge clk);
`ifdef MULTDIV_SEQ_EARLY_TERM_EN
        issue(1'b1, 1'b0, OP_MULT, 1'b0, 4, 5);
`else
        issue(1'b1, 1'b0, OP_MULT, 1'b0, N_MULT, N_MULT + 1);
`endif
        wait_cnt(3);
        mplier_zero = 1'b1;
        drain(40);
        mplier_zero = 1'b0;

        // mplier_zero never shortens a divide
        @(negedge clk);
        mplier_zero = 1'b1;
        issue(1'b0, 1'b1, OP_DIV, 1'b0, N_DIV, N_DIV + 1);
        drain(60);
        mplier_zero = 1'b0;

        repeat (3) @(negedge clk);
        check("final_idle", 32'({busy, result_rdy}), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
